debounce: RTL and testbench
===========================

# debounce

Per-bit input conditioner: synchronises WIDTH asynchronous inputs (buttons, switches, external status lines) into the clk domain and suppresses bounce/glitches with a per-bit stability counter. It sits directly upstream of the edge detector. Its `out` is a clean, registered level that the edge detector converts into single-cycle rising/falling/both strobes.

## Interface
- `WIDTH`, default 1: number of independent input bits.
- `SYNC_STAGES`, default 2: flip-flops in each synchroniser chain; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 16: number of consecutive qualified cycles (cycles with `ce`=1) the synchronised input must differ from `out` before `out` follows it; legal range 1..65535.
- `clk`, input, 1: clock, rising edge.
- `anrst`, input, 1: reset, asynchronous, active-low.
- `ce`, input, 1: count enable (prescaler tick); the stability counters advance only when it is 1. Tie to 1 for counting in raw clk cycles.
- `in`, input, WIDTH: asynchronous raw inputs.
- `out`, output, WIDTH: debounced level, registered.
- `busy`, output, WIDTH: per bit, 1 while the synchronised input differs from `out` (a change is being qualified).

## Operation
- Each bit is fully independent; there is no cross-bit interaction.
- Synchroniser: `s[i]` is the last stage of a SYNC_STAGES-deep chain on `in[i]`. All stages reset to 0. No logic sits between stages.
- Counter: `cnt[i]` is $clog2(DEBOUNCE_CYCLES) bits wide, with a minimum of 1 bit, and resets to 0.
- Per-bit update on every clk edge, in priority order:
  - `s[i]` == `out[i]`: `cnt[i]` <= 0. Any glitch back to the current level restarts qualification.
  - `s[i]` != `out[i]`, `ce`=1, `cnt[i]` == DEBOUNCE_CYCLES-1: `out[i]` <= `s[i]`, `cnt[i]` <= 0.
  - `s[i]` != `out[i]`, `ce`=1, otherwise: `cnt[i]` <= `cnt[i]` + 1.
  - `s[i]` != `out[i]`, `ce`=0: `cnt[i]` holds.
- The counter never wraps: it is cleared either on a match or on the terminal count.
- `busy[i]` = (`s[i]` != `out[i]`), combinational from registers only. It is 0 in reset.
- Effective two-state FSM per bit:
  - STABLE (`busy`=0) goes to QUALIFY when `s` != `out`.
  - QUALIFY goes to STABLE on terminal count (`out` flips) or when `s` returns to `out` (`out` unchanged).
- Reset values: `out`=0, `busy`=0, all sync stages=0, all counters=0.
- Reset assertion mid-qualification clears everything immediately, with no output glitch beyond the async clear to 0.
- An input held at 1 through reset release produces `out` 0→1 after the full latency. The downstream edge detector sees one rising edge, and this is intended.

## Timing
- Latency with `ce`=1 constantly: a clean step on `in[i]` that is set up before clk edge 1 appears on `out[i]` after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Example: defaults give `out` at edge 18.
- Add up to 1 cycle of synchroniser uncertainty for truly asynchronous edges.
- With `ce` pulsing every N cycles, the debounce portion is DEBOUNCE_CYCLES qualified ticks. The first tick counted is the first `ce`=1 edge at which `s` != `out`.
- Minimum accepted pulse: a level must persist at `s` for DEBOUNCE_CYCLES consecutive qualified cycles. Shorter pulses leave `out` untouched; `busy` still pulses.
- `out` changes at most once per DEBOUNCE_CYCLES qualified cycles per bit.
- DEBOUNCE_CYCLES=1: `out` follows `s` at the first `ce`=1 edge after the change.
- `out` and `busy` are glitch-free, fed by registers only. No combinational path runs from `in` or `ce` to any output.

## Test plan
- Reset/idle: hold `anrst`=0 with `in`=all-1s, then release, defaults, `ce`=1. `out` and `busy` are 0 during reset; `busy` rises at edge 2, and `out` rises at edge 18 after release; exactly one 0→1 transition.
- Bounce rejection: WIDTH=1, DEBOUNCE_CYCLES=16, `in` toggles every 5 cycles for 100 cycles, then holds 1. `out` stays 0 during toggling and goes to 1 exactly 18 edges after the final settle.
- Exact threshold: a synchronised pulse of 15 cycles leaves `out`=0; a pulse of 16 cycles sets `out`=1, which returns to 0 only after 16 stable cycles of 0.
- Prescaled `ce`: `ce`=1 every 4th cycle, DEBOUNCE_CYCLES=4, clean step on `in`. `out` updates on the 4th qualified `ce` tick after `s` changes; `cnt` holds between ticks.
- Per-bit independence with WIDTH=8: bit0 bounces, bit3 makes a clean step, the others are static. Only bit3 changes, at the nominal latency; `busy` is asserted only on bits 0 and 3.
- Reset mid-qualification: assert `anrst` when `cnt`=10. `out`, `busy`, and `cnt` clear at once; after release, the full latency is required again.

Source files
------------

// File: rtl/debounce.sv
// Per-bit input conditioner: a SYNC_STAGES-deep synchroniser followed by a
// stability counter that lets out follow the synchronised input only after
// DEBOUNCE_CYCLES consecutive qualified (ce=1) cycles of disagreement.
module debounce #(
   parameter int unsigned WIDTH           = 1,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             anrst,
   input  logic             ce,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] busy
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
   logic [WIDTH-1:0]                  s;
   logic [CW-1:0]                     cnt [WIDTH];

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         sync <= '0;
      end else begin
         sync[0] <= in;
         for (int unsigned k = 1; k < SYNC_STAGES; k++)
            sync[k] <= sync[k-1];
      end
   end

   assign s = sync[SYNC_STAGES-1];

   // A match always clears the counter, so it never needs to wrap.
   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         out <= '0;
         for (int unsigned i = 0; i < WIDTH; i++)
            cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s[i] == out[i]) begin
               cnt[i] <= '0;
            end else if (ce) begin
               if (cnt[i] == TERM) begin
                  out[i] <= s[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CW'(1);
               end
            end
         end
      end
   end

   assign busy = s ^ out;

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce: reset/idle, bounce rejection with per-bit
// independence, exact threshold, mid-qualification reset, prescaled ce, DC=1.
module tb_debounce;

   logic       clk;
   logic       anrst;
   logic       ce_a, ce_b, ce_c;
   logic [7:0] in_a, out_a, busy_a;
   logic       in_b, out_b, busy_b;
   logic       in_c, out_c, busy_c;

   int total = 0;
   int bad   = 0;

   debounce #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut_a (
      .clk(clk), .anrst(anrst), .ce(ce_a), .in(in_a), .out(out_a), .busy(busy_a));

   debounce #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_b (
      .clk(clk), .anrst(anrst), .ce(ce_b), .in(in_b), .out(out_b), .busy(busy_b));

   debounce #(.WIDTH(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_c (
      .clk(clk), .anrst(anrst), .ce(ce_c), .in(in_c), .out(out_c), .busy(busy_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      anrst = 1'b0;
      in_a  = '0;
      in_b  = 1'b0;
      in_c  = 1'b0;
      ce_a  = 1'b1;
      ce_b  = 1'b0;
      ce_c  = 1'b1;
      tick(2);
      anrst = 1'b1;
      tick(2);
   endtask

   // bounce pattern on bit 0: 5 cycles high, 5 low, ...
   function automatic logic val(input int j);
      return (((j - 1) / 5) % 2) == 0;
   endfunction

   initial begin
      logic [7:0] eo, eb;
      logic       eb0;

      // reset/idle with inputs held high through release
      anrst = 1'b0;
      in_a  = 8'hFF;
      ce_a  = 1'b1;
      in_b  = 1'b0;
      ce_b  = 1'b0;
      in_c  = 1'b0;
      ce_c  = 1'b1;
      tick(3);
      chk("rst_out", 16'(out_a), 16'h0);
      chk("rst_busy", 16'(busy_a), 16'h0);
      anrst = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         eo = (k >= 18) ? 8'hFF : 8'h00;
         eb = (k >= 2 && k < 18) ? 8'hFF : 8'h00;
         chk($sformatf("rel_out_e%0d", k), 16'(out_a), 16'(eo));
         chk($sformatf("rel_busy_e%0d", k), 16'(busy_a), 16'(eb));
      end

      // bit0 bounces every 5 cycles while bit3 steps cleanly
      do_reset();
      for (int j = 1; j <= 100; j++) begin
         in_a = {4'b0000, 1'b1, 2'b00, val(j)};
         tick(1);
         eo  = (j >= 18) ? 8'h08 : 8'h00;
         eb0 = (j >= 2) ? val(j - 1) : 1'b0;
         eb  = {4'b0000, (j >= 2 && j < 18), 2'b00, eb0};
         chk($sformatf("bnc_out_c%0d", j), 16'(out_a), 16'(eo));
         chk($sformatf("bnc_busy_c%0d", j), 16'(busy_a), 16'(eb));
      end
      in_a = 8'h09;
      tick(17);
      chk("settle_out_e17", 16'(out_a), 16'h08);
      chk("settle_busy_e17", 16'(busy_a), 16'h01);
      tick(1);
      chk("settle_out_e18", 16'(out_a), 16'h09);

      // exact threshold on bit1: 15-cycle pulse rejected
      do_reset();
      in_a = 8'h02;
      tick(10);
      chk("p15_busy", 16'(busy_a), 16'h02);
      tick(5);
      in_a = 8'h00;
      tick(5);
      chk("p15_out", 16'(out_a), 16'h00);
      chk("p15_busy_end", 16'(busy_a), 16'h00);
      // 16-cycle pulse accepted, then needs 16 cycles of 0 to fall
      in_a = 8'h02;
      tick(16);
      in_a = 8'h00;
      tick(1);
      chk("p16_out_e17", 16'(out_a), 16'h00);
      tick(1);
      chk("p16_out_e18", 16'(out_a), 16'h02);
      tick(15);
      chk("p16_fall_e33", 16'(out_a), 16'h02);
      tick(1);
      chk("p16_fall_e34", 16'(out_a), 16'h00);

      // reset mid-qualification
      do_reset();
      in_a = 8'h20;
      tick(18);
      chk("mid_pre_out", 16'(out_a), 16'h20);
      in_a = 8'h28;
      tick(12);
      chk("mid_cnt10", 16'(dut_a.cnt[3]), 16'd10);
      chk("mid_busy", 16'(busy_a), 16'h08);
      anrst = 1'b0;
      #1;
      chk("mid_clr_out", 16'(out_a), 16'h00);
      chk("mid_clr_busy", 16'(busy_a), 16'h00);
      chk("mid_clr_cnt", 16'(dut_a.cnt[3]), 16'd0);
      tick(2);
      chk("mid_hold_busy", 16'(busy_a), 16'h00);
      anrst = 1'b1;
      tick(17);
      chk("mid_rel_e17", 16'(out_a), 16'h00);
      tick(1);
      chk("mid_rel_e18", 16'(out_a), 16'h28);

      // prescaled ce: tick on every 4th cycle, DEBOUNCE_CYCLES=4
      do_reset();
      in_b = 1'b1;
      for (int j = 1; j <= 18; j++) begin
         ce_b = ((j % 4) == 0);
         tick(1);
         chk($sformatf("ce_out_c%0d", j), 16'(out_b), 16'(j >= 16));
         chk($sformatf("ce_busy_c%0d", j), 16'(busy_b), 16'(j >= 2 && j < 16));
         chk($sformatf("ce_cnt_c%0d", j), 16'(dut_b.cnt[0]),
             16'((j >= 4 && j < 16) ? (j / 4) : 0));
      end

      // DEBOUNCE_CYCLES=1 with three sync stages
      do_reset();
      in_c = 1'b1;
      tick(3);
      chk("dc1_out_e3", 16'(out_c), 16'h0);
      chk("dc1_busy_e3", 16'(busy_c), 16'h1);
      tick(1);
      chk("dc1_out_e4", 16'(out_c), 16'h1);
      chk("dc1_busy_e4", 16'(busy_c), 16'h0);
      in_c = 1'b0;
      ce_c = 1'b0;
      tick(6);
      chk("dc1_hold_out", 16'(out_c), 16'h1);
      chk("dc1_hold_busy", 16'(busy_c), 16'h1);
      ce_c = 1'b1;
      tick(1);
      chk("dc1_fall_out", 16'(out_c), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
